// File: rtl/serial_cmd_decoder.sv
// Decodes 5-byte SYNC/addr/data_hi/data_lo/csum frames into register writes
// and answers every completed frame with an ACK or NAK byte.
module serial_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        rx_idle,
  input  logic        tx_busy,
  input  logic        err_clr,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_busy,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DHI,
    DLO,
    CSUM,
    RESP
  } state_t;

  state_t     r_state;
  logic [7:0] r_addr;
  logic [7:0] r_dhi;
  logic [7:0] r_dlo;
  logic [7:0] r_resp;

  logic [7:0] w_sum;
  logic       w_good;
  logic       w_in_frame;
  logic       w_abort;
  logic       w_inc;

  assign w_sum      = r_addr + r_dhi + r_dlo + rx_data;
  assign w_good     = (w_sum == 8'h00);
  assign w_in_frame = (r_state == ADDR) || (r_state == DHI) ||
                      (r_state == DLO)  || (r_state == CSUM);
  // A byte arriving alongside idle wins; idle only aborts an empty cycle.
  assign w_abort    = w_in_frame && rx_idle && !rx_ready;
  assign w_inc      = w_abort ||
                      ((r_state == CSUM) && rx_ready && !w_good) ||
                      ((r_state == RESP) && rx_ready);
  assign frame_busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= 8'h00;
      r_dhi     <= 8'h00;
      r_dlo     <= 8'h00;
      r_resp    <= 8'h00;
      reg_wr    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 16'h0000;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      err_count <= 8'h00;
    end else begin
      reg_wr   <= 1'b0;
      tx_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (rx_ready && (rx_data == SYNC_BYTE)) r_state <= ADDR;
        end
        ADDR: begin
          if (rx_ready) begin
            r_addr  <= rx_data;
            r_state <= DHI;
          end else if (rx_idle) begin
            r_state <= IDLE;
          end
        end
        DHI: begin
          if (rx_ready) begin
            r_dhi   <= rx_data;
            r_state <= DLO;
          end else if (rx_idle) begin
            r_state <= IDLE;
          end
        end
        DLO: begin
          if (rx_ready) begin
            r_dlo   <= rx_data;
            r_state <= CSUM;
          end else if (rx_idle) begin
            r_state <= IDLE;
          end
        end
        CSUM: begin
          if (rx_ready) begin
            r_state <= RESP;
            if (w_good) begin
              reg_wr    <= 1'b1;
              reg_addr  <= r_addr;
              reg_wdata <= {r_dhi, r_dlo};
              r_resp    <= ACK_BYTE;
            end else begin
              r_resp    <= NAK_BYTE;
            end
          end else if (rx_idle) begin
            r_state <= IDLE;
          end
        end
        RESP: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= r_resp;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (err_clr) begin
        err_count <= 8'h00;
      end else if (w_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

endmodule

// File: doc/serial_cmd_decoder.md
SERIAL_CMD_DECODER -- requirements
Module: serial_cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, response to a good frame.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, response to a bad-checksum frame.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  received byte, valid only while rx_ready=1.
REQ-007 SHALL have port rx_ready  input  1  one-cycle byte-received strobe from the serial receiver.
REQ-008 SHALL have port rx_idle  input  1  receiver line-idle flag (level).
REQ-009 SHALL have port tx_busy  input  1  serial transmitter busy (level).
REQ-010 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-011 SHALL have port reg_wr  output  1  one-cycle register-write strobe.
REQ-012 SHALL have port reg_addr  output  8  write address, valid with reg_wr, held until next write.
REQ-013 SHALL have port reg_wdata  output  16  write data {data_hi,data_lo}, valid with reg_wr, held until next write.
REQ-014 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-015 SHALL have port tx_data  output  8  response byte, valid while tx_start=1.
REQ-016 SHALL have port frame_busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port err_count  output  8  saturating count of aborted, bad-checksum and dropped frames/bytes.

Function
REQ-018 Frame format SHALL be 5 bytes: SYNC_BYTE, addr, data_hi, data_lo, csum; good when (addr+data_hi+data_lo+csum) mod 256 == 0.
REQ-019 FSM states SHALL be IDLE, ADDR, DHI, DLO, CSUM, RESP.
REQ-020 IDLE: rx_ready with rx_data==SYNC_BYTE -> ADDR; any other byte ignored, no error counted.
REQ-021 ADDR/DHI/DLO: rx_ready captures byte into shadow register, advances to DHI/DLO/CSUM respectively.
REQ-022 SYNC_BYTE received mid-frame SHALL be treated as ordinary data (no resync).
REQ-023 CSUM on rx_ready: good -> reg_wr=1 on the next cycle with reg_addr/reg_wdata updated in that same cycle, response=ACK_BYTE; bad -> no reg_wr, response=NAK_BYTE, err_count+1; both go to RESP.
REQ-024 RESP: when tx_busy=0, assert tx_start for exactly one cycle with tx_data=response, then -> IDLE; while tx_busy=1, wait indefinitely.
REQ-025 tx_start SHALL be asserted earliest one cycle after entry to RESP.
REQ-026 rx_ready in RESP SHALL drop the byte and increment err_count.
REQ-027 rx_idle=1 in ADDR, DHI, DLO or CSUM without rx_ready in the same cycle SHALL abort to IDLE and increment err_count; rx_idle is ignored in IDLE and RESP.
REQ-028 rx_ready and rx_idle in the same cycle: byte is processed, idle ignored that cycle.
REQ-029 err_count SHALL saturate at 8'hFF; err_clr and an increment in the same cycle SHALL yield 0.
REQ-030 At most one increment per cycle SHALL occur.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, reg_wr=0, tx_start=0, frame_busy=0, reg_addr=0, reg_wdata=0, tx_data=0, err_count=0, shadow registers=0, irrespective of clk.
REQ-032 Reset mid-frame or in RESP SHALL discard the frame with no reg_wr or tx_start after release.
REQ-033 First rx_ready accepted SHALL be in the cycle after rst deasserts.

Verification
REQ-034 Bytes A5,10,12,34,AA (sum 0x00) -> one reg_wr, reg_addr=0x10, reg_wdata=0x1234, then tx_start with tx_data=06; err_count=0.
REQ-035 Bytes A5,10,12,34,AB -> no reg_wr, tx_start with tx_data=15, err_count=1.
REQ-036 Bytes A5,10 then rx_idle=1 -> back to IDLE, frame_busy=0, err_count=1, no reg_wr/tx_start; next good frame decodes normally.
REQ-037 Good frame with tx_busy held high 50 cycles -> tx_start only in first cycle after tx_busy falls; a byte sent during the wait is dropped, err_count=1.
REQ-038 Bytes 00,FF,A5,01,00,02,FD -> garbage ignored, reg_wr addr=0x01 data=0x0002, tx_data=06.
REQ-039 err_count forced to 255 by 256 bad frames stays 255; err_clr coinciding with a bad frame -> 0; rst asserted during DLO -> all outputs 0 immediately.
